// File: rtl/demultiplexor_1an_registrado.sv
// Registered 1-to-N demultiplexer: valid/ready input, one holding register per output channel.
// Define DEMUX_DROP_COUNT_EN to build the saturating counter of dropped out-of-range words.

module demultiplexor_1an_registrado #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 3
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [WIDTH-1:0]          X,
   input  logic                      X_Valid,
   output logic                      X_Ready,
   input  logic [SEL_W-1:0]          Selector,
   input  logic                      Mode,
   output logic [CHANNELS*WIDTH-1:0] Y,
   output logic [CHANNELS-1:0]       Y_Valid,
   input  logic [CHANNELS-1:0]       Y_Ready,
   input  logic                      Err_Clr,
   output logic                      Error,
   output logic [7:0]                Drop_Count
);

   localparam int PTR_W = $clog2(CHANNELS);

   logic [PTR_W-1:0]          ptr_p0;
   logic [SEL_W-1:0]          tgt;
   logic [PTR_W-1:0]          tgt_idx;
   logic                      in_range;
   logic                      x_ready;
   logic                      accept;
   logic                      drop;
   logic [CHANNELS-1:0]       wr_en;
   logic [CHANNELS*WIDTH-1:0] y_data_p0;
   logic [CHANNELS-1:0]       vld_p0;
   logic                      err_p0;

   // Input side: target selection and combinational ready
   always_comb begin
      tgt      = Mode ? SEL_W'(ptr_p0) : Selector;
      in_range = (int'(tgt) < CHANNELS);
      tgt_idx  = PTR_W'(tgt);
      x_ready  = in_range ? (!vld_p0[tgt_idx] | Y_Ready[tgt_idx]) : 1'b1;
   end

   assign accept = X_Valid & x_ready;
   assign drop   = accept & ~in_range;

   always_comb begin
      wr_en = '0;
      if (accept && in_range)
         wr_en[tgt_idx] = 1'b1;
   end

   // Stage p0: per-channel holding registers; a write wins over a same-edge drain
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         y_data_p0 <= '0;
         vld_p0    <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en[i]) begin
               y_data_p0[i*WIDTH +: WIDTH] <= X;
               vld_p0[i]                   <= 1'b1;
            end else if (vld_p0[i] && Y_Ready[i]) begin
               vld_p0[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr_p0 <= '0;
      end else if (accept && Mode) begin
         if (ptr_p0 == PTR_W'(CHANNELS - 1))
            ptr_p0 <= '0;
         else
            ptr_p0 <= ptr_p0 + PTR_W'(1);
      end
   end

   // A fresh drop outranks a coincident clear so no error is lost
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         err_p0 <= 1'b0;
      else if (drop)
         err_p0 <= 1'b1;
      else if (Err_Clr)
         err_p0 <= 1'b0;
   end

`ifdef DEMUX_DROP_COUNT_EN
   logic [7:0] drop_cnt_p0;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         drop_cnt_p0 <= 8'd0;
      else if (Err_Clr)
         drop_cnt_p0 <= drop ? 8'd1 : 8'd0;
      else if (drop && (drop_cnt_p0 != 8'd255))
         drop_cnt_p0 <= drop_cnt_p0 + 8'd1;
   end

   assign Drop_Count = drop_cnt_p0;
`else
   assign Drop_Count = 8'd0;
`endif

   assign X_Ready = x_ready;
   assign Y       = y_data_p0;
   assign Y_Valid = vld_p0;
   assign Error   = err_p0;

endmodule

// File: tb/tb_demultiplexor_1an_registrado.sv
// Scoreboard bench for demultiplexor_1an_registrado: per-channel expected-word queues,
// occupancy/pointer/error model updated each cycle, monitor pops on every output handshake.

module tb_demultiplexor_1an_registrado;

   localparam int W  = 4;
   localparam int N  = 4;
   localparam int SW = 3;

   logic            Clk = 1'b0;
   logic            Rst_n = 1'b1;
   logic [W-1:0]    X;
   logic            X_Valid;
   logic            X_Ready;
   logic [SW-1:0]   Selector;
   logic            Mode;
   logic [N*W-1:0]  Y;
   logic [N-1:0]    Y_Valid;
   logic [N-1:0]    Y_Ready;
   logic            Err_Clr;
   logic            Error;
   logic [7:0]      Drop_Count;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] q [N][$];
   logic [N-1:0] mfull;
   int           mptr;
   bit           merr;
   int           mcnt;
   bit           rand_rdy;

   demultiplexor_1an_registrado #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .X(X), .X_Valid(X_Valid), .X_Ready(X_Ready),
      .Selector(Selector), .Mode(Mode), .Y(Y), .Y_Valid(Y_Valid), .Y_Ready(Y_Ready),
      .Err_Clr(Err_Clr), .Error(Error), .Drop_Count(Drop_Count)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mfull = '0;
      mptr  = 0;
      merr  = 1'b0;
      mcnt  = 0;
      for (int i = 0; i < N; i++) q[i].delete();
   endtask

   // Reference model: evaluated before each rising edge from the current inputs
   always @(negedge Clk) begin : model
      int       t;
      logic [1:0] ti;
      bit       inr;
      bit       exr;
      bit       acc;
      if (Rst_n) begin
         t   = Mode ? mptr : int'(Selector);
         ti  = t[1:0];
         inr = (t < N);
         exr = inr ? (!mfull[ti] || Y_Ready[ti]) : 1'b1;
         chk("x_ready", 32'(X_Ready), 32'(exr));
         chk("y_valid", 32'(Y_Valid), 32'(mfull));
         chk("error", 32'(Error), 32'(merr));
         chk("drop_count", 32'(Drop_Count), 32'(mcnt));
         acc   = X_Valid && exr;
         mfull = mfull & ~Y_Ready;
         if (acc && inr) begin
            mfull[ti] = 1'b1;
            q[ti].push_back(X);
         end
         if (acc && Mode) mptr = (mptr + 1) % N;
         if (acc && !inr) begin
            merr = 1'b1;
`ifdef DEMUX_DROP_COUNT_EN
            mcnt = Err_Clr ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
`endif
         end else if (Err_Clr) begin
            merr = 1'b0;
            mcnt = 0;
         end
      end
   end

   // Monitor: every completed output handshake must deliver the oldest expected word
   always @(negedge Clk) begin : monitor
      logic [W-1:0] e;
      if (Rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (Y_Valid[i] && Y_Ready[i]) begin
               if (q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word ch%0d got %0h expected none", i, Y[i*W +: W]);
               end else begin
                  e = q[i].pop_front();
                  chk($sformatf("data_ch%0d", i), 32'(Y[i*W +: W]), 32'(e));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      X_Valid = 1'b0;
      repeat (n) begin
         if (rand_rdy) Y_Ready = N'($urandom);
         tick();
      end
   endtask

   task automatic send(input logic [W-1:0] x, input int sel, input bit md);
      bit done = 1'b0;
      X        = x;
      Selector = sel[SW-1:0];
      Mode     = md;
      X_Valid  = 1'b1;
      for (int c = 0; c < 64 && !done; c++) begin
         if (rand_rdy) begin
            Y_Ready = N'($urandom);
            Err_Clr = ($urandom_range(7, 0) == 0);
         end
         @(negedge Clk);
         done = X_Ready;
         tick();
      end
      X_Valid = 1'b0;
      Err_Clr = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got no ready expected ready within 64 cycles");
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      X = '0; X_Valid = 1'b0; Selector = '0; Mode = 1'b0;
      Y_Ready = '0; Err_Clr = 1'b0; rand_rdy = 1'b0;
      model_reset();
      Rst_n = 1'b0;
      #2;
      chk("rst_x_ready", 32'(X_Ready), 32'd1);
      chk("rst_y", 32'(Y), 32'd0);
      chk("rst_y_valid", 32'(Y_Valid), 32'd0);
      chk("rst_error", 32'(Error), 32'd0);
      chk("rst_drop_count", 32'(Drop_Count), 32'd0);
      #10 Rst_n = 1'b1;
      tick();

      // Directed fill with every consumer stalled
      for (int s = 0; s < N; s++) send(4'b1011, s, 1'b0);
      chk("fill_y_valid", 32'(Y_Valid), 32'hF);
      chk("fill_y", 32'(Y), 32'hBBBB);
      for (int s = 0; s < N; s++) begin
         Selector = SW'(s);
         #1 chk($sformatf("fill_blocked_sel%0d", s), 32'(X_Ready), 32'd0);
      end
      tick();

      // Same-edge drain and refill of channel 2
      Y_Ready = 4'b0100;
      send(4'b0110, 2, 1'b0);
      Y_Ready = '0;
      chk("refill_y_valid", 32'(Y_Valid), 32'hF);
      chk("refill_slice2", 32'(Y[11:8]), 32'h6);
      Y_Ready = 4'hF;
      idle(2);

      // Out-of-range selections are swallowed and flagged
      send(4'h5, 4, 1'b0);
      send(4'h9, 5, 1'b0);
      chk("oor_error", 32'(Error), 32'd1);
      chk("oor_y_valid", 32'(Y_Valid), 32'd0);
`ifdef DEMUX_DROP_COUNT_EN
      chk("oor_drop_count", 32'(Drop_Count), 32'd2);
`else
      chk("oor_drop_count", 32'(Drop_Count), 32'd0);
`endif
      Err_Clr = 1'b1;
      tick();
      Err_Clr = 1'b0;
      chk("clr_error", 32'(Error), 32'd0);
      chk("clr_drop_count", 32'(Drop_Count), 32'd0);

      // Round-robin wrap; the next word must land on channel 2
      Y_Ready = 4'hF;
      for (int w = 1; w <= 6; w++) send(W'(w), 0, 1'b1);
      idle(1);
      Y_Ready = '0;
      send(4'hA, 0, 1'b1);
      chk("rr_ptr_after_wrap", 32'(Y_Valid), 32'b0100);
      Y_Ready = 4'hF;
      idle(2);

      // Asynchronous reset between edges with held words and a pending error
      Y_Ready = '0;
      send(4'h3, 0, 1'b0);
      send(4'hC, 2, 1'b0);
      send(4'h1, 7, 1'b0);
      chk("pre_rst_y_valid", 32'(Y_Valid), 32'b0101);
      chk("pre_rst_error", 32'(Error), 32'd1);
      Selector = '0;
      #2 Rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_y_valid", 32'(Y_Valid), 32'd0);
      chk("async_rst_y", 32'(Y), 32'd0);
      chk("async_rst_error", 32'(Error), 32'd0);
      chk("async_rst_x_ready", 32'(X_Ready), 32'd1);
      #3 Rst_n = 1'b1;
      tick();

      // 300 consecutive drops
      Mode = 1'b0; Selector = 3'd6; X_Valid = 1'b1;
      repeat (300) tick();
      X_Valid = 1'b0;
`ifdef DEMUX_DROP_COUNT_EN
      chk("sat_drop_count", 32'(Drop_Count), 32'd255);
`else
      chk("sat_drop_count", 32'(Drop_Count), 32'd0);
`endif
      Err_Clr = 1'b1;
      tick();
      Err_Clr = 1'b0;

      // Randomized traffic against the model
      rand_rdy = 1'b1;
      repeat (1500) begin
         if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
         send(W'($urandom), int'($urandom_range(7, 0)), ($urandom_range(3, 0) == 0));
      end
      rand_rdy = 1'b0;
      Y_Ready = 4'hF;
      idle(3);
      for (int i = 0; i < N; i++)
         chk($sformatf("drained_ch%0d", i), 32'(q[i].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/demultiplexor_1an_registrado.md
# demultiplexor_1an_registrado

Parametrised, registered 1-to-N demultiplexer with a valid/ready handshake on the input and on every output channel. Each channel has a one-word holding register, so a stalled consumer only blocks traffic addressed to that channel. It supports directed routing through `Selector` and a sequential round-robin mode. Out-of-range selections are flagged rather than silently aliased. It is the clocked successor of the combinational 1-to-4 demux and sits between a single producer and up to N independent consumers.

## Interface
Parameters:
- `WIDTH`, 4: data word width.
- `CHANNELS`, 4: number of output channels, 2..16.
- `SEL_W`, 3: selector width, ≥ clog2(CHANNELS); extra codes are out-of-range.

Ports:
- `Clk`, in, 1: single clock, rising edge.
- `Rst_n`, in, 1: reset, asynchronous, active-low.
- `X`, in, WIDTH: input word.
- `X_Valid`, in, 1: input word present.
- `X_Ready`, out, 1: block can take `X` this cycle.
- `Selector`, in, SEL_W: destination channel in directed mode.
- `Mode`, in, 1: 0 = directed, 1 = sequential round-robin.
- `Y`, out, CHANNELS*WIDTH: channel i data at bits [i*WIDTH +: WIDTH].
- `Y_Valid`, out, CHANNELS: per-channel holding register full.
- `Y_Ready`, in, CHANNELS: per-channel consumer accepts.
- `Err_Clr`, in, 1: clears `Error`.
- `Error`, out, 1: sticky out-of-range flag.
- `Drop_Count`, out, 8: count of dropped words (see Configuration).

## Operation
- Target channel T: `Selector` when `Mode`=0; internal pointer `Ptr` when `Mode`=1.
- `Ptr` resets to 0. It advances by 1 modulo CHANNELS on each accepted word in mode 1 and wraps from CHANNELS-1 to 0. It holds its value in mode 0 and across mode changes.
- A word is accepted on a rising edge when `X_Valid`=1 and `X_Ready`=1.
- When T is in range, `X_Ready` = !`Y_Valid`[T] | `Y_Ready`[T]. This is a combinational path from `Y_Ready` to `X_Ready`.
- When T ≥ CHANNELS (mode 0 only), `X_Ready`=1. The word is accepted and dropped, and no channel changes. `Error` is set on that edge.
- Channel i on each edge:
  - Accept into i: `Y` slice ← `X` and `Y_Valid`[i] ← 1. This also applies when draining on the same edge.
  - Drain only (`Y_Valid`[i]&`Y_Ready`[i]): `Y_Valid`[i] ← 0 and the data slice holds.
  - Otherwise: hold.
- Only one channel is written per edge. Non-target channels drain independently.
- `Error` is cleared by `Err_Clr`. If a new error and `Err_Clr` occur on the same edge, the set wins.
- `Y` data is meaningful only while the corresponding `Y_Valid` bit is 1.

## Timing
- Reset, asynchronous while `Rst_n`=0:
  - `Y`=0, `Y_Valid`=0, `Ptr`=0, `Error`=0, `Drop_Count`=0.
  - `X_Ready` = 1 during and after reset.
- Latency: a word accepted at edge k is visible on `Y`/`Y_Valid` immediately after edge k. This is one cycle, and throughput is one word per cycle.
- Full channel with `Y_Ready`=0 deasserts `X_Ready` when it is the target. `X` must be held stable by the producer until accepted.
- Reset asserted mid-transfer discards all held words. No partial state survives.
- `Mode` or `Selector` changes take effect in the same cycle; `X_Ready` follows combinationally.

## Configuration
- `DEMUX_DROP_COUNT_EN` defined:
  - `Drop_Count` increments by 1 on every dropped (out-of-range) accepted word.
  - It saturates at 255 and is cleared by `Err_Clr` or reset.
  - When `Err_Clr` coincides with a drop, the result is 1.
- `DEMUX_DROP_COUNT_EN` undefined: no counter logic is built and `Drop_Count` is tied to 0.

## Test plan
- Directed fill:
  - Stimulus: `Mode`=0, `X`=4'b1011, `Selector`=0,1,2,3 on consecutive cycles, all `Y_Ready`=0.
  - Response: `Y_Valid`=4'b1111, every slice = 1011, and `X_Ready`=0 for any in-range selector afterwards.
- Backpressure and same-cycle refill:
  - Stimulus: channel 2 full, `Y_Ready`[2]=1, new `X`=4'b0110 to channel 2.
  - Response: accepted on that edge, `Y_Valid`[2] stays 1, slice 2 = 0110.
- Out-of-range:
  - Stimulus: `Selector`=3'b100 then 3'b101 with `X_Valid`=1.
  - Response: both accepted, no `Y_Valid` change, `Error`=1, and with the macro `Drop_Count`=2.
  - Follow-up: `Err_Clr` pulse → `Error`=0, `Drop_Count`=0.
- Round-robin wrap:
  - Stimulus: `Mode`=1, 6 words 1..6 with all `Y_Ready`=1.
  - Response: words land on channels 0,1,2,3,0,1, and `Ptr`=2 at the end.
- Reset mid-operation:
  - Stimulus: `Rst_n`=0 asynchronously between edges while `Y_Valid`=4'b0101.
  - Response: `Y_Valid`=0, `Y`=0, and `Error`=0 immediately, without waiting for a clock edge.
- Saturation (macro defined):
  - Stimulus: 300 dropped words.
  - Response: `Drop_Count`=255.
